cache_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the set-associative cache's single core port.
- Serialises read requests from core 0 and core 1.
- Drives the cache address and holds it stable until the cache signals ready.
- Returns the byte and hit/miss status to the winning requester; keeps saturating hit/miss statistics.
- Includes a watchdog so a stuck cache cannot lock both cores out.

---
 rtl/cache_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Round-robin arbiter and sequencer that shares the cache's single core port
// between two read requesters. A granted address is presented to the cache and
// held until the cache reports ready. The byte and hit/miss status then return
// to the winning core as a one-cycle strobe. A watchdog aborts an access the
// cache never completes, so one stuck access cannot lock out both cores.
// Saturating hit/miss counters are kept for statistics.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req0/addr0   core 0 read request and address (held until rsp_valid[0])
//   req1/addr1   core 1 read request and address (held until rsp_valid[1])
//   gnt          one-hot grant, high through ISSUE and RESP for the winner
//   rsp_valid    one-hot, one-cycle response strobe
//   rsp_data     returned byte; holds until the next response
//   rsp_hit      1 = access hit; holds until the next response
//   rsp_err      1 = watchdog abort; holds until the next response
//   cache_addr   address presented to the cache
//   cache_valid  high while an address is presented (ISSUE)
//   cache_data   byte returned by the cache
//   cache_ready  cache has completed the access
//   cache_hit    cache hit flag
//   cache_miss   cache miss flag
//   hit_cnt      saturating count of hits
//   miss_cnt     saturating count of misses (includes ambiguous flag pairs)
//   busy         arbiter is not in IDLE
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_valid,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_ready,
  input  logic              cache_hit,
  input  logic              cache_miss,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy
);

  // Watchdog only has to reach TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cvalid_q, cvalid_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic                last_q, last_d;   // index of the core served last
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                pick;             // winning core index in IDLE
  logic                hit_class;        // only an unambiguous hit counts as hit

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      cvalid_q    <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      last_q      <= 1'b1;   // core 0 wins the first tie
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      cvalid_q    <= cvalid_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
    end
  end

  assign pick      = (req0 && req1) ? ~last_q : req1;
  assign hit_class = cache_hit & ~cache_miss;

  // NOTE: every signal driven here is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = 2'b00;       // strobe: high only in the cycle after entry
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    cvalid_d    = cvalid_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    last_d      = last_q;
    wdog_d      = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d    = pick ? 2'b10 : 2'b01;
          addr_d   = pick ? addr1 : addr0;
          cvalid_d = 1'b1;
          wdog_d   = '0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Ready takes priority over an abort in the same cycle.
        if (cache_ready) begin
          rsp_data_d  = cache_data;
          rsp_hit_d   = hit_class;
          rsp_err_d   = 1'b0;
          if (hit_class) begin
            if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
          end else begin
            if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
          end
          cvalid_d    = 1'b0;
          rsp_valid_d = gnt_q;
          state_d     = S_RESP;
        end else if (wdog_q == WD_LAST) begin
          rsp_data_d  = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b1;
          cvalid_d    = 1'b0;
          rsp_valid_d = gnt_q;
          state_d     = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_RESP: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = S_GAP;
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_err     = rsp_err_q;
  assign cache_addr  = addr_q;
  assign cache_valid = cvalid_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Self-checking bench. Each test task pushes the responses it expects into a
// scoreboard queue as it raises requests; a monitor pops and compares them as
// the arbiter strobes rsp_valid. A behavioural cache answers after a chosen
// number of ISSUE cycles with chosen hit/miss flags, or never.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;

  logic              clk;
  logic              rst;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        gnt, rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_hit, rsp_err;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_valid;
  logic [DATA_W-1:0] cache_data;
  logic              cache_ready, cache_hit, cache_miss;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;
  logic              busy;

  cache_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .addr0      (addr0),
    .req1       (req1),
    .addr1      (addr1),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_hit    (rsp_hit),
    .rsp_err    (rsp_err),
    .cache_addr (cache_addr),
    .cache_valid(cache_valid),
    .cache_data (cache_data),
    .cache_ready(cache_ready),
    .cache_hit  (cache_hit),
    .cache_miss (cache_miss),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                core;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;
    logic              err;
    int                issue_len;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Cache model controls.
  int          cache_lat   = 1;
  bit          never_ready = 1'b0;
  logic [1:0]  cache_flags = 2'b01;   // {hit, miss} returned with ready
  logic [7:0]  salt        = 8'h00;

  // Requester model: outstanding requests per core.
  int pend0 = 0;
  int pend1 = 0;
  int issue_cycles = 0;

  function automatic logic [DATA_W-1:0] cache_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Behavioural cache: ready in the cache_lat-th ISSUE cycle, garbage otherwise.
  initial begin
    int cnt;
    cnt = 0;
    cache_ready = 1'b0;
    cache_data  = '0;
    cache_hit   = 1'b0;
    cache_miss  = 1'b0;
    forever begin
      @(negedge clk);
      if (cache_valid === 1'b1) begin
        cnt++;
        if (!never_ready && cnt == cache_lat) begin
          cache_ready = 1'b1;
          cache_data  = cache_byte(cache_addr);
          {cache_hit, cache_miss} = cache_flags;
        end else begin
          cache_ready = 1'b0;
          cache_data  = 8'($urandom);
          cache_hit   = 1'($urandom_range(1, 0));
          cache_miss  = 1'($urandom_range(1, 0));
        end
      end else begin
        cnt = 0;
        cache_ready = 1'b0;
      end
    end
  end

  // Monitor and requester: checks address stability and each response, then
  // drops or re-presents the request.
  initial begin
    exp_t       e;
    logic [1:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        issue_cycles = 0;
      end else begin
        if (cache_valid === 1'b1) begin
          issue_cycles++;
          if (sb.size() > 0) begin
            checks++;
            if (cache_addr !== sb[0].addr) begin
              failures++;
              $display("FAIL addr_stable: cache_addr=%0h expected=%0h", cache_addr, sb[0].addr);
            end
          end
        end
        if (rsp_valid !== 2'b00) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: rsp_valid=%b with no response expected", rsp_valid);
          end else begin
            e = sb.pop_front();
            exp_v = (e.core == 1) ? 2'b10 : 2'b01;
            checks++;
            if (rsp_valid !== exp_v) begin
              failures++;
              $display("FAIL rsp_valid: got=%b expected=%b", rsp_valid, exp_v);
            end
            checks++;
            if (gnt !== exp_v) begin
              failures++;
              $display("FAIL gnt_in_resp: got=%b expected=%b", gnt, exp_v);
            end
            checks++;
            if (rsp_data !== e.data) begin
              failures++;
              $display("FAIL rsp_data: got=%0h expected=%0h", rsp_data, e.data);
            end
            checks++;
            if (rsp_hit !== e.hit || rsp_err !== e.err) begin
              failures++;
              $display("FAIL rsp_status: hit/err got=%b%b expected=%b%b",
                       rsp_hit, rsp_err, e.hit, e.err);
            end
            checks++;
            if (issue_cycles != e.issue_len) begin
              failures++;
              $display("FAIL issue_len: got=%0d expected=%0d", issue_cycles, e.issue_len);
            end
            if (e.core == 0) begin
              pend0--;
              req0 = (pend0 > 0);
            end else begin
              pend1--;
              req1 = (pend1 > 0);
            end
          end
          issue_cycles = 0;
        end
      end
    end
  end

  task automatic push(input int core, input logic [ADDR_W-1:0] addr,
                      input logic hit, input logic err, input int len);
    exp_t e;
    e.core      = core;
    e.addr      = addr;
    e.data      = err ? '0 : cache_byte(addr);
    e.hit       = hit;
    e.err       = err;
    e.issue_len = len;
    sb.push_back(e);
  endtask

  task automatic start(input int core, input logic [ADDR_W-1:0] addr, input int n);
    @(negedge clk);
    if (core == 0) begin
      addr0 = addr; pend0 = n; req0 = 1'b1;
    end else begin
      addr1 = addr; pend1 = n; req1 = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((pend0 != 0 || pend1 != 0 || sb.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_timeout: pending=%0d/%0d queued=%0d busy=%b", name, pend0, pend1,
               sb.size(), busy);
      pend0 = 0; pend1 = 0; req0 = 1'b0; req1 = 1'b0;
      sb.delete();
    end
  endtask

  task automatic wait_cache_valid(input string name);
    int n;
    n = 0;
    while (cache_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL %s_no_issue: cache_valid=%b expected=1", name, cache_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_data, rsp_hit, rsp_err, cache_addr, cache_valid,
         hit_cnt, miss_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b rsp_valid=%b data=%0h addr=%0h cv=%b hits=%0d misses=%0d busy=%b",
               gnt, rsp_valid, rsp_data, cache_addr, cache_valid, hit_cnt, miss_cnt, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_miss();
    salt = 8'h3C; cache_flags = 2'b01; cache_lat = 5;
    push(0, 32'h1461, 1'b0, 1'b0, 5);
    start(0, 32'h1461, 1);
    wait_cache_valid("miss");
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL miss_gnt: got=%b expected=01", gnt);
    end
    wait_done("miss");
    checks++;
    if (miss_cnt !== 2'd1 || hit_cnt !== 2'd0) begin
      failures++;
      $display("FAIL miss_counters: hit/miss got=%0d/%0d expected=0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_hit();
    int n;
    logic [DATA_W-1:0] exp_d;
    salt = 8'hC3; cache_flags = 2'b10; cache_lat = 2;
    exp_d = cache_byte(32'h1461);
    push(0, 32'h1461, 1'b1, 1'b0, 2);
    start(0, 32'h1461, 1);
    n = 0;
    while (rsp_valid === 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_cycle: gnt=%b rsp_valid=%b busy=%b expected 00/00/1", gnt, rsp_valid, busy);
    end
    checks++;
    if (rsp_data !== exp_d || rsp_hit !== 1'b1) begin
      failures++;
      $display("FAIL rsp_hold: data/hit got=%0h/%b expected=%0h/1", rsp_data, rsp_hit, exp_d);
    end
    wait_done("hit");
    checks++;
    if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) begin
      failures++;
      $display("FAIL hit_counters: hit/miss got=%0d/%0d expected=1/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_timeout();
    never_ready = 1'b1;
    push(0, 32'h0BAD, 1'b0, 1'b1, TIMEOUT);
    start(0, 32'h0BAD, 1);
    wait_done("abort");
    checks++;
    if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) begin
      failures++;
      $display("FAIL abort_counters: hit/miss got=%0d/%0d expected=1/1", hit_cnt, miss_cnt);
    end
    never_ready = 1'b0; cache_flags = 2'b10; cache_lat = 3; salt = 8'h5A;
    push(0, 32'hF634, 1'b1, 1'b0, 3);
    start(0, 32'hF634, 1);
    wait_done("after_abort");
    checks++;
    if (hit_cnt !== 2'd2 || miss_cnt !== 2'd1) begin
      failures++;
      $display("FAIL after_abort_counters: hit/miss got=%0d/%0d expected=2/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_issue();
    never_ready = 1'b1;
    start(0, 32'h7D6B, 1);     // abandoned: no response expected
    wait_cache_valid("rst_mid");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    req0 = 1'b0; pend0 = 0;
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_data, rsp_hit, rsp_err, cache_addr, cache_valid,
         hit_cnt, miss_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset: gnt=%b rsp_valid=%b addr=%0h cv=%b hits=%0d misses=%0d busy=%b",
               gnt, rsp_valid, cache_addr, cache_valid, hit_cnt, miss_cnt, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    never_ready = 1'b0; cache_flags = 2'b01; cache_lat = 1; salt = 8'h77;
    push(1, 32'h8863, 1'b0, 1'b0, 1);
    start(1, 32'h8863, 1);
    wait_cache_valid("core1");
    checks++;
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL core1_gnt: got=%b expected=10", gnt);
    end
    wait_done("core1");
    checks++;
    if (miss_cnt !== 2'd1 || hit_cnt !== 2'd0) begin
      failures++;
      $display("FAIL core1_counters: hit/miss got=%0d/%0d expected=0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_fairness();
    // Last served is core 1, so core 0 takes the first tie.
    cache_flags = 2'b10; cache_lat = 1; salt = 8'h11;
    push(0, 32'h512D, 1'b1, 1'b0, 1);
    push(1, 32'hF257, 1'b1, 1'b0, 1);
    push(0, 32'h512D, 1'b1, 1'b0, 1);
    push(1, 32'hF257, 1'b1, 1'b0, 1);
    @(negedge clk);
    addr0 = 32'h512D; addr1 = 32'hF257;
    pend0 = 2; pend1 = 2;
    req0 = 1'b1; req1 = 1'b1;
    wait_done("fair");
    checks++;
    if (hit_cnt !== 2'd3) begin
      failures++;
      $display("FAIL hit_saturate: got=%0d expected=3", hit_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] flags [5];
    flags = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b01};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    salt = 8'hE1;
    for (int i = 0; i < 5; i++) begin
      cache_flags = flags[i];
      cache_lat   = 1 + (i % 3);
      push(0, 32'h3000 + i, 1'b0, 1'b0, 1 + (i % 3));
      start(0, 32'h3000 + i, 1);
      wait_done("sat");
    end
    checks++;
    if (miss_cnt !== 2'd3 || hit_cnt !== 2'd0) begin
      failures++;
      $display("FAIL miss_saturate: hit/miss got=%0d/%0d expected=0/3", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_timeout();
    test_reset_mid_issue();
    test_fairness();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
